// File: rtl/counter_sequencer_if.sv
// Control and status bundle for counter_sequencer.
interface counter_sequencer_if #(
   parameter int BITS = 4
);
   logic            start;
   logic            stop;
   logic            pause;
   logic            auto_reload;
   logic [BITS-1:0] limit;
   logic [BITS-1:0] Q;
   logic            busy;
   logic            paused;
   logic            done;

   modport master (
      output start, stop, pause, auto_reload, limit,
      input  Q, busy, paused, done
   );

   modport slave (
      input  start, stop, pause, auto_reload, limit,
      output Q, busy, paused, done
   );
endinterface

// File: rtl/counter_sequencer.sv
// Run controller around a BITS-wide up-counter with one-shot and
// auto-reload modes, pause/hold, stop and a registered done pulse.
module counter_sequencer #(
   parameter int BITS = 4
) (
   input logic                clk,
   input logic                reset_n,
   counter_sequencer_if.slave bus
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] HOLD = 2'd2;
   localparam logic [1:0] DONE = 2'd3;

   logic [1:0]      state_q, state_d;
   logic [BITS-1:0] q_q, q_d;
   logic [BITS-1:0] limit_q, limit_d;
   logic            mode_q, mode_d;
   logic            busy_q, busy_d;
   logic            paused_q, paused_d;
   logic            done_q, done_d;
   logic            accept;

   assign accept = (state_q == IDLE || state_q == DONE)
                 && bus.start
                 && (bus.limit != '0);

   always_comb begin
      state_d = state_q;
      q_d     = q_q;
      limit_d = limit_q;
      mode_d  = mode_q;
      done_d  = 1'b0;
      if (bus.stop) begin
         state_d = IDLE;
         q_d     = '0;
      end else if (accept) begin
         state_d = RUN;
         q_d     = '0;
         limit_d = bus.limit;
         mode_d  = bus.auto_reload;
      end else begin
         unique case (state_q)
            RUN: begin
               // pause outranks the terminal action on the same edge
               if (bus.pause) begin
                  state_d = HOLD;
               end else if (q_q == limit_q) begin
                  done_d = 1'b1;
                  if (mode_q) begin
                     q_d = '0;
                  end else begin
                     state_d = DONE;
                  end
               end else begin
                  q_d = q_q + 1'b1;
               end
            end
            HOLD: begin
               if (!bus.pause) begin
                  state_d = RUN;
               end
            end
            default: begin
            end
         endcase
      end
      busy_d   = (state_d == RUN) || (state_d == HOLD);
      paused_d = (state_d == HOLD);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         q_q      <= '0;
         limit_q  <= '0;
         mode_q   <= 1'b0;
         busy_q   <= 1'b0;
         paused_q <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         q_q      <= q_d;
         limit_q  <= limit_d;
         mode_q   <= mode_d;
         busy_q   <= busy_d;
         paused_q <= paused_d;
         done_q   <= done_d;
      end
   end

   assign bus.Q      = q_q;
   assign bus.busy   = busy_q;
   assign bus.paused = paused_q;
   assign bus.done   = done_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Scoreboard bench for counter_sequencer: directed per-cycle vectors
// push expected outputs; a monitor pops and compares after each edge.
module tb_counter_sequencer;

   typedef struct packed {
      logic [3:0] q;
      logic       busy;
      logic       paused;
      logic       done;
   } exp_t;

   logic clk;
   logic reset_n;
   int   checks;
   int   failures;
   exp_t sb[$];

   counter_sequencer_if #(.BITS(4)) bus ();

   counter_sequencer #(.BITS(4)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic compare(input string name, input exp_t e);
      exp_t a;
      a = '{q: bus.Q, busy: bus.busy,
            paused: bus.paused, done: bus.done};
      checks++;
      if (a !== e) begin
         failures++;
         $display("FAIL %s got Q=%0d busy=%0b paused=%0b done=%0b want Q=%0d busy=%0b paused=%0b done=%0b",
                  name, a.q, a.busy, a.paused, a.done,
                  e.q, e.busy, e.paused, e.done);
      end
   endtask

   // one clock of stimulus plus the outputs expected after that edge
   task automatic step(
      input logic st, input logic sp, input logic pa,
      input logic ar, input logic [3:0] lim,
      input logic [3:0] eq, input logic eb,
      input logic ep, input logic ed
   );
      @(negedge clk);
      bus.start       = st;
      bus.stop        = sp;
      bus.pause       = pa;
      bus.auto_reload = ar;
      bus.limit       = lim;
      sb.push_back('{q: eq, busy: eb, paused: ep, done: ed});
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() != 0) begin
            e = sb.pop_front();
            compare("cycle", e);
         end
      end
   end

   initial begin : stim
      checks   = 0;
      failures = 0;
      reset_n  = 1'b0;
      bus.start       = 1'b0;
      bus.stop        = 1'b0;
      bus.pause       = 1'b0;
      bus.auto_reload = 1'b0;
      bus.limit       = 4'd0;
      #12;
      compare("reset", '{q: 4'd0, busy: 1'b0,
                         paused: 1'b0, done: 1'b0});
      @(negedge clk);
      reset_n = 1'b1;

      // one-shot limit 5
      step(1, 0, 0, 0, 5, 0, 1, 0, 0);
      for (int i = 1; i <= 5; i++)
         step(0, 0, 0, 0, 5, 4'(i), 1, 0, 0);
      step(0, 0, 0, 0, 5, 5, 0, 0, 1);
      for (int i = 0; i < 10; i++)
         step(0, 0, 0, 0, 5, 5, 0, 0, 0);
      step(0, 1, 0, 0, 5, 0, 0, 0, 0);

      // auto-reload limit 3, period of 4
      step(1, 0, 0, 1, 3, 0, 1, 0, 0);
      for (int k = 1; k <= 8; k++)
         step(0, 0, 0, 1, 3, 4'(k % 4), 1, 0, (k % 4) == 0);
      step(0, 1, 0, 1, 3, 0, 0, 0, 0);

      // one-shot limit 9 with a 3-cycle pause at Q=2
      step(1, 0, 0, 0, 9, 0, 1, 0, 0);
      step(0, 0, 0, 0, 9, 1, 1, 0, 0);
      step(0, 0, 0, 0, 9, 2, 1, 0, 0);
      for (int i = 0; i < 3; i++)
         step(0, 0, 1, 0, 9, 2, 1, 1, 0);
      step(0, 0, 0, 0, 9, 2, 1, 0, 0);
      for (int i = 3; i <= 9; i++)
         step(0, 0, 0, 0, 9, 4'(i), 1, 0, 0);
      step(0, 0, 0, 0, 9, 9, 0, 0, 1);
      step(0, 0, 0, 0, 9, 9, 0, 0, 0);
      step(0, 1, 0, 0, 9, 0, 0, 0, 0);

      // auto-reload limit 6, stop+pause at Q=4, then start with limit 0
      step(1, 0, 0, 1, 6, 0, 1, 0, 0);
      for (int i = 1; i <= 4; i++)
         step(0, 0, 0, 1, 6, 4'(i), 1, 0, 0);
      step(0, 1, 1, 1, 6, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0);

      // limit 15 auto-reload; restart attempt with limit 2 at Q=7
      step(1, 0, 0, 1, 15, 0, 1, 0, 0);
      for (int i = 1; i <= 7; i++)
         step(0, 0, 0, 1, 15, 4'(i), 1, 0, 0);
      for (int i = 8; i <= 15; i++)
         step(1, 0, 0, 0, 2, 4'(i), 1, 0, 0);
      step(1, 0, 0, 0, 2, 0, 1, 0, 1);
      step(1, 0, 0, 0, 2, 1, 1, 0, 0);
      step(1, 1, 0, 0, 2, 0, 0, 0, 0);

      // one-shot limit 5, async reset between edges at Q=3
      step(1, 0, 0, 0, 5, 0, 1, 0, 0);
      for (int i = 1; i <= 3; i++)
         step(0, 0, 0, 0, 5, 4'(i), 1, 0, 0);
      @(negedge clk);
      bus.start = 1'b0;
      #2 reset_n = 1'b0;
      #1 compare("async_reset", '{q: 4'd0, busy: 1'b0,
                                  paused: 1'b0, done: 1'b0});
      #1 reset_n = 1'b1;
      for (int i = 0; i < 3; i++)
         step(0, 0, 0, 0, 5, 0, 0, 0, 0);
      step(1, 0, 0, 0, 5, 0, 1, 0, 0);
      step(0, 0, 0, 0, 5, 1, 1, 0, 0);

      for (int i = 0; i < 10 && sb.size() != 0; i++)
         @(negedge clk);
      if (sb.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL drain got %0d pending want 0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
